// File: rtl/serial_pkg.sv
// Shared constants and FSM state encodings for the processor-side serial console bridge.
package serial_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_fifo.sv
// Show-ahead synchronous FIFO. Extra pointer MSB separates full from empty;
// a push into a full FIFO is accepted only when a pop frees the head slot on the same edge.
module serial_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_console_bridge.sv
// Bridges the processor byte port to an 8N1 UART: buffered TX serialiser and
// buffered, synchronised RX deserialiser with framing/overrun error pulse.
module serial_console_bridge
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_ADDR_W  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_data_in,
    input  logic       proc_wren_in,
    input  logic       proc_rden_in,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_error_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    // ---------------- TX path ----------------
    tx_state_t                 tx_state;
    logic [CNT_W-1:0]          tx_cnt;
    logic [2:0]                tx_bit;
    logic [UART_DATA_BITS-1:0] tx_shift;
    logic [UART_DATA_BITS-1:0] tx_head;
    logic                      tx_full;
    logic                      tx_empty;
    logic                      tx_push;
    logic                      tx_pop;

    // Ready is judged on pre-edge fullness, so a write to a full FIFO is lost
    // even when the serialiser drains a slot on that same edge.
    assign proc_ready_out = !tx_full;
    assign tx_push        = proc_wren_in && !tx_full;
    assign tx_pop         = (tx_state == TX_IDLE) && !tx_empty;

    serial_fifo #(.WIDTH(UART_DATA_BITS), .ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (proc_data_in),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    // The line register follows the pre-edge state, so every bit lags its state by one clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx_out <= 1'b1;
                    tx_cnt      <= '0;
                    if (!tx_empty) begin
                        tx_shift <= tx_head;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    uart_tx_out <= 1'b0;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    uart_tx_out <= tx_shift[0];
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == LAST_BIT) tx_state <= TX_STOP;
                        else                    tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    uart_tx_out <= 1'b1;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_t                 rx_state;
    logic [CNT_W-1:0]          rx_cnt;
    logic [2:0]                rx_bit;
    logic [UART_DATA_BITS-1:0] rx_shift;
    logic                      rx_meta;
    logic                      rx_sync;
    logic                      rx_full;
    logic                      rx_empty;
    logic                      rx_stop_done;
    logic                      rx_push;
    logic                      rx_pop;

    assign rx_stop_done   = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_push        = rx_stop_done && rx_sync;
    assign rx_pop         = proc_rden_in && !rx_empty;
    assign proc_valid_out = !rx_empty;

    serial_fifo #(.WIDTH(UART_DATA_BITS), .ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (proc_data_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_error_out <= 1'b0;
        end else begin
            rx_meta      <= uart_rx_in;
            rx_sync      <= rx_meta;
            // Bad stop bit, or a completed byte with nowhere to go.
            rx_error_out <= (rx_stop_done && !rx_sync) || (rx_push && rx_full && !rx_pop);
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[UART_DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
                        else                    rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_console_bridge.sv
// Directed bench for serial_console_bridge at 4 clocks per bit and 16-deep FIFOs.
module tb_serial_console_bridge;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] proc_data_in;
    logic       proc_wren_in;
    logic       proc_rden_in;
    logic [7:0] proc_data_out;
    logic       proc_valid_out;
    logic       proc_ready_out;
    logic       uart_rx_in;
    logic       uart_tx_out;
    logic       rx_error_out;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int err_cnt   = 0;
    int cyc       = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] wr_data;
        logic [7:0] exp_byte;
        logic       exp_stop;
    } tx_vec_t;

    typedef struct {
        logic [7:0] rx_data;
        logic       rx_stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_err;
    } rx_vec_t;

    tx_vec_t tx_vec [4];
    rx_vec_t rx_vec [5];

    serial_console_bridge #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .proc_data_in   (proc_data_in),
        .proc_wren_in   (proc_wren_in),
        .proc_rden_in   (proc_rden_in),
        .proc_data_out  (proc_data_out),
        .proc_valid_out (proc_valid_out),
        .proc_ready_out (proc_ready_out),
        .uart_rx_in     (uart_rx_in),
        .uart_tx_out    (uart_tx_out),
        .rx_error_out   (rx_error_out)
    );

    // ---------------- clock / monitors ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (rx_error_out === 1'b1) err_cnt <= err_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, check_cnt);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic write_byte(input logic [7:0] d);
        proc_data_in = d;
        proc_wren_in = 1'b1;
        @(negedge clock);
        proc_wren_in = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = d[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx_in = stop;
        repeat (CPB) @(negedge clock);
        uart_rx_in = 1'b1;
    endtask

    // Waits (bounded) for a start bit, then samples each bit in its middle.
    task automatic capture_tx(output logic [7:0] d, output logic stop, output int fall_cyc);
        int n;
        n = 0;
        d = '0;
        stop = 1'b0;
        while (uart_tx_out !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("tx_start_seen", 32'(n < 400), 32'd1);
        fall_cyc = cyc;
        repeat (CPB / 2) @(negedge clock);
        check("tx_start_bit", 32'(uart_tx_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clock);
            d[k] = uart_tx_out;
        end
        repeat (CPB) @(negedge clock);
        stop = uart_tx_out;
    endtask

    task automatic count_tx_lows(input int clks, output int lows);
        lows = 0;
        for (int i = 0; i < clks; i++) begin
            @(negedge clock);
            if (uart_tx_out !== 1'b1) lows++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0]  d;
        logic        s;
        int          fc;
        int          lows;
        int          e0;
        logic [39:0] line;
        logic [39:0] exp_line;
        logic [9:0]  frame;

        tx_vec[0] = '{8'h55, 8'h55, 1'b1};
        tx_vec[1] = '{8'hFF, 8'hFF, 1'b1};
        tx_vec[2] = '{8'h00, 8'h00, 1'b1};
        tx_vec[3] = '{8'h81, 8'h81, 1'b1};

        rx_vec[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        rx_vec[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        rx_vec[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        rx_vec[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        rx_vec[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};

        reset        = 1'b0;
        uart_rx_in   = 1'b1;
        proc_data_in = '0;
        proc_wren_in = 1'b0;
        proc_rden_in = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_tx",    32'(uart_tx_out),    32'd1);
        check("rst_ready", 32'(proc_ready_out), 32'd1);
        check("rst_valid", 32'(proc_valid_out), 32'd0);
        check("rst_data",  32'(proc_data_out),  32'd0);
        check("rst_error", 32'(rx_error_out),   32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset in the middle of a TX frame with RX data buffered
        send_rx(8'h5A, 1'b1);
        repeat (3) @(negedge clock);
        check("t1_valid_before", 32'(proc_valid_out), 32'd1);
        check("t1_data_before",  32'(proc_data_out),  32'h5A);
        write_byte(8'hC3);
        write_byte(8'h81);
        repeat (12) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t1_tx_in_reset",    32'(uart_tx_out),    32'd1);
        check("t1_ready_in_reset", 32'(proc_ready_out), 32'd1);
        check("t1_valid_in_reset", 32'(proc_valid_out), 32'd0);
        check("t1_data_in_reset",  32'(proc_data_out),  32'd0);
        @(negedge clock);
        reset = 1'b1;
        count_tx_lows(80, lows);
        check("t1_line_idle_after", 32'(lows), 32'd0);
        check("t1_valid_after",     32'(proc_valid_out), 32'd0);

        // Single write of 0x48: exact line waveform, clock by clock
        write_byte(8'h48);
        check("t2_tx_write_edge", 32'(uart_tx_out), 32'd1);
        @(negedge clock);
        check("t2_tx_edge1", 32'(uart_tx_out), 32'd1);
        frame = {1'b1, 8'h48, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            line[i]     = uart_tx_out;
            exp_line[i] = frame[i / CPB];
        end
        check("t2_line_48", 32'(line[31:0]), 32'(exp_line[31:0]));
        check("t2_line_48_hi", 32'(line[39:32]), 32'(exp_line[39:32]));
        @(negedge clock);
        check("t2_line_idle_after", 32'(uart_tx_out), 32'd1);
        repeat (4) @(negedge clock);

        // TX vector table
        for (int v = 0; v < 4; v++) begin
            write_byte(tx_vec[v].wr_data);
            capture_tx(d, s, fc);
            check($sformatf("txv%0d_byte", v), 32'(d), 32'(tx_vec[v].exp_byte));
            check($sformatf("txv%0d_stop", v), 32'(s), 32'(tx_vec[v].exp_stop));
            repeat (4) @(negedge clock);
        end

        // Burst of 18 writes: 18th lost, 17 frames with one idle clock between
        fork
            begin : burst_writer
                for (int i = 0; i < 18; i++) begin
                    check($sformatf("t3_ready_%0d", i), 32'(proc_ready_out), 32'(i < 17));
                    write_byte(8'(i));
                end
            end
            begin : burst_reader
                logic [7:0] bd;
                logic       bs;
                int         bfc;
                int         prev;
                prev = 0;
                for (int f = 0; f < 17; f++) begin
                    capture_tx(bd, bs, bfc);
                    check($sformatf("t3_byte_%0d", f), 32'(bd), 32'(f));
                    check($sformatf("t3_stop_%0d", f), 32'(bs), 32'd1);
                    if (f > 0) check($sformatf("t3_gap_%0d", f), 32'(bfc - prev), 32'(10 * CPB + 1));
                    prev = bfc;
                end
            end
        join
        count_tx_lows(60, lows);
        check("t3_no_extra_frame", 32'(lows), 32'd0);
        check("t3_ready_after", 32'(proc_ready_out), 32'd1);

        // RX vector table
        for (int v = 0; v < 5; v++) begin
            e0 = err_cnt;
            send_rx(rx_vec[v].rx_data, rx_vec[v].rx_stop);
            repeat (3) @(negedge clock);
            check($sformatf("rxv%0d_valid", v), 32'(proc_valid_out), 32'(rx_vec[v].exp_valid));
            check($sformatf("rxv%0d_data", v),  32'(proc_data_out),  32'(rx_vec[v].exp_data));
            check($sformatf("rxv%0d_err", v),   32'(err_cnt - e0),   32'(rx_vec[v].exp_err));
            if (rx_vec[v].exp_valid) begin
                proc_rden_in = 1'b1;
                @(negedge clock);
                proc_rden_in = 1'b0;
                check($sformatf("rxv%0d_valid_after_pop", v), 32'(proc_valid_out), 32'd0);
            end
            repeat (4) @(negedge clock);
        end

        // rden while empty is ignored
        proc_rden_in = 1'b1;
        @(negedge clock);
        proc_rden_in = 1'b0;
        check("empty_rden_valid", 32'(proc_valid_out), 32'd0);

        // One-clock glitch is a false start
        e0 = err_cnt;
        uart_rx_in = 1'b0;
        @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (20) @(negedge clock);
        check("t5_glitch_valid", 32'(proc_valid_out), 32'd0);
        check("t5_glitch_err",   32'(err_cnt - e0),   32'd0);

        // Overrun: 17 frames with no pops
        e0 = err_cnt;
        for (int i = 1; i <= 17; i++) begin
            send_rx(8'(i), 1'b1);
            if (i <= 16) exp_q.push_back(8'(i));
        end
        repeat (3) @(negedge clock);
        check("t6_overrun_err",   32'(err_cnt - e0),   32'd1);
        check("t6_valid_full",    32'(proc_valid_out), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_pop_%0d", i), 32'(proc_data_out), 32'(exp_q.pop_front()));
            proc_rden_in = 1'b1;
            @(negedge clock);
        end
        proc_rden_in = 1'b0;
        check("t6_valid_drained", 32'(proc_valid_out), 32'd0);

        // 20 frames while popping: storage index wraps past the end
        e0 = err_cnt;
        for (int i = 1; i <= 20; i++) begin
            send_rx(8'(i), 1'b1);
            exp_q.push_back(8'(i));
            repeat (3) @(negedge clock);
            check($sformatf("t6w_valid_%0d", i), 32'(proc_valid_out), 32'd1);
            check($sformatf("t6w_data_%0d", i),  32'(proc_data_out),  32'(exp_q.pop_front()));
            proc_rden_in = 1'b1;
            @(negedge clock);
            proc_rden_in = 1'b0;
            check($sformatf("t6w_empty_%0d", i), 32'(proc_valid_out), 32'd0);
        end
        check("t6w_no_err", 32'(err_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
